// File: rtl/unified_mem_ctrl.sv
// Single-port word memory shared by an instruction-fetch read port and a data
// read/write port, with fixed-priority or round-robin arbitration and fixed wait states.
module unified_mem_ctrl #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ARB_MODE    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 last_d_q, last_d_d;   // 1: data port won the last grant
  logic                 port_q, port_d;       // 1: data port owns the transaction
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 we_q, we_d;
  logic [3:0]           sel_q, sel_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          if_data_q, if_data_d;
  logic [31:0]          d_rdata_q, d_rdata_d;
  logic                 if_ready_q, if_ready_d;
  logic                 d_ready_q, d_ready_d;
  logic                 busy_q, busy_d;

  logic [31:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] if_idx_c, d_idx_c;
  logic                 unused_addr;

  // Byte offset and bits above the array size are don't-care, so addresses alias.
  assign if_idx_c    = if_addr[ADDR_BITS+1:2];
  assign d_idx_c     = d_addr[ADDR_BITS+1:2];
  assign unused_addr = ^{if_addr[31:ADDR_BITS+2], if_addr[1:0],
                         d_addr[31:ADDR_BITS+2], d_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      last_d_q   <= 1'b0;
      port_q     <= 1'b0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= 4'd0;
      wdata_q    <= 32'd0;
      if_data_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_d_q   <= last_d_d;
      port_q     <= port_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    port_d    = port_q;
    idx_d     = idx_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    if_data_d = if_data_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (d_req || if_req) begin
          port_d   = d_req && ((ARB_MODE == 0) || !if_req || !last_d_q);
          last_d_d = port_d;
          idx_d    = port_d ? d_idx_c : if_idx_c;
          we_d     = port_d && d_we;
          sel_d    = d_sel;
          wdata_d  = d_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Read data is captured on entry to DONE and then held until the next read.
    if (state_d == S_DONE && !we_d) begin
      if (port_d) d_rdata_d = mem[idx_d];
      else        if_data_d = mem[idx_d];
    end

    if_ready_d = (state_d == S_DONE) && !port_d;
    d_ready_d  = (state_d == S_DONE) && port_d;
    busy_d     = (state_d != S_IDLE);
  end

  // Storage is never reset; a write commits only at the edge ending DONE.
  always_ff @(posedge clk) begin
    if (rst && state_q == S_DONE && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign if_data  = if_data_q;
  assign if_ready = if_ready_q;
  assign d_rdata  = d_rdata_q;
  assign d_ready  = d_ready_q;
  assign busy     = busy_q;

endmodule

// File: doc/unified_mem_ctrl.md
UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, word-address width; storage depth is 2**ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, legal 0..7, extra access cycles per transaction.
REQ-003 SHALL have parameter ARB_MODE, default 0, arbitration mode: 0 = data port fixed priority, 1 = round-robin.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port if_req  input  1  instruction-fetch read request, level.
REQ-007 SHALL have port if_addr  input  32  fetch byte address.
REQ-008 SHALL have port if_data  output  32  fetch read data.
REQ-009 SHALL have port if_ready  output  1  one-cycle fetch completion pulse.
REQ-010 SHALL have port d_req  input  1  data request, level.
REQ-011 SHALL have port d_we  input  1  data write enable (1 = write, 0 = read).
REQ-012 SHALL have port d_sel  input  4  byte-lane select; bit i selects byte lane [8i+7:8i].
REQ-013 SHALL have port d_addr  input  32  data byte address.
REQ-014 SHALL have port d_wdata  input  32  write data.
REQ-015 SHALL have port d_rdata  output  32  data read data.
REQ-016 SHALL have port d_ready  output  1  one-cycle data completion pulse.
REQ-017 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL form the word index from addr[ADDR_BITS+1:2]; addr[1:0] and all higher bits are ignored, so addresses wrap modulo 4*2**ADDR_BITS.
REQ-019 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE; with WAIT_CYCLES=0, IDLE -> DONE directly.
REQ-020 SHALL grant in IDLE at the edge where a request is sampled high, and latch port, address, we, sel and wdata at that edge.
REQ-021 SHALL hold WAIT for exactly WAIT_CYCLES cycles using a 3-bit down-counter.
REQ-022 SHALL assert the granted port's ready for exactly the single DONE cycle, i.e. WAIT_CYCLES+1 cycles after the grant edge.
REQ-023 SHALL, for reads, drive the word onto if_data or d_rdata during DONE and hold it until that port's next read completion.
REQ-024 SHALL, for writes, update only lanes with d_sel bit set, at the edge ending DONE; d_sel=0000 with d_we=1 completes the handshake with no write.
REQ-025 SHALL, on data writes, leave d_rdata unchanged.
REQ-026 SHALL return full 32-bit words on reads regardless of d_sel; if_req is read-only.
REQ-027 SHALL, with both requests high in IDLE and ARB_MODE=0, grant the data port.
REQ-028 SHALL, with both requests high in IDLE and ARB_MODE=1, grant the port not granted last; after reset, last-granted = fetch, so data wins first.
REQ-029 SHALL treat a request still high in the IDLE cycle after DONE as a new transaction; back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
REQ-030 SHALL reflect a read in the cycle after a preceding write's DONE.
REQ-031 SHALL ignore input changes on the non-granted port and on the granted port after the grant edge.

Reset
REQ-032 SHALL, while rst=0, force state IDLE, counter 0, last-granted = fetch, if_ready=0, d_ready=0, busy=0, if_data=0, d_rdata=0.
REQ-033 SHALL, on reset asserted mid-transaction, abort with no ready pulse and discard any pending write (memory unchanged).
REQ-034 SHALL NOT reset or initialise storage contents.

Verification
REQ-035 SHALL cover: WAIT_CYCLES=1, write 0x010 = 0xDEADBEEF sel 1111 -> d_ready 2 cycles after grant; read 0x010 -> d_rdata 0xDEADBEEF.
REQ-036 SHALL cover: then write 0x010 data 0x0000AB00 sel 0010 -> read 0x010 returns 0xDEADABEF.
REQ-037 SHALL cover: if_req and d_req held high together, 4 transactions -> ARB_MODE=0 grants D,D,D,D; ARB_MODE=1 grants D,I,D,I.
REQ-038 SHALL cover: ADDR_BITS=10, write 0x1000 = 0x12345678 -> fetch read of 0x0000 returns 0x12345678.
REQ-039 SHALL cover: rst pulled low during WAIT of a write to 0x020 -> no d_ready, all outputs 0, later read of 0x020 returns the prior value.
REQ-040 SHALL cover: WAIT_CYCLES=0, if_req held high for addresses 0,4,8 -> if_ready pulses every 2 cycles with the correct words.
